// File: rtl/rnd_clk_mon.sv
// rnd_clk_mon: measures phases/period of the LFSR random clock, flags bad periods.
// Define RND_CLK_MON_SYNC_EN to add a 2-flop input synchronizer for async sources.
module rnd_clk_mon #(
  parameter int CW         = 8,
  parameter int MIN_PERIOD = 2,
  parameter int MAX_PERIOD = 64,
  parameter int ECW        = 16
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_rnd_clk,
  input  logic          i_clr,
  output logic [CW-1:0] o_hi_len,
  output logic [CW-1:0] o_lo_len,
  output logic [CW:0]   o_period,
  output logic          o_valid,
  output logic [CW:0]   o_min_period,
  output logic [CW:0]   o_max_period,
  output logic [ECW-1:0] o_edge_cnt,
  output logic          o_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HI1  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW:0]   P_MIN   = (CW+1)'(MIN_PERIOD);
  localparam logic [CW:0]   P_MAX   = (CW+1)'(MAX_PERIOD);

  logic          s;
  logic          s_d;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          rise;
  logic          fall;
  logic          run_rise;
  logic [CW:0]   per;
  logic          per_bad;
  logic          stuck;

`ifdef RND_CLK_MON_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) sync_q <= '0;
    else         sync_q <= {sync_q[0], i_rnd_clk};
  end

  assign s = sync_q[1];
`else
  assign s = i_rnd_clk;
`endif

  assign rise     = s & ~s_d;
  assign fall     = ~s & s_d;
  assign run_rise = rise && (state == S_RUN);
  assign per      = {1'b0, o_hi_len} + {1'b0, cnt};
  assign per_bad  = (per < P_MIN) || (per > P_MAX);
  // a saturated counter outside idle means the clock stopped toggling
  assign stuck    = (cnt == CNT_MAX) && (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s_d          <= 1'b0;
      cnt          <= '0;
      state        <= S_IDLE;
      o_hi_len     <= '0;
      o_lo_len     <= '0;
      o_period     <= '0;
      o_valid      <= 1'b0;
      o_min_period <= '1;
      o_max_period <= '0;
      o_edge_cnt   <= '0;
      o_err        <= 1'b0;
    end else begin
      s_d     <= s;
      o_valid <= 1'b0;
      if (i_clr) begin
        cnt          <= CW'(1);
        state        <= S_IDLE;
        o_min_period <= '1;
        o_max_period <= '0;
        o_edge_cnt   <= '0;
        o_err        <= 1'b0;
      end else begin
        if (rise || fall)       cnt <= CW'(1);
        else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        if (fall) o_hi_len <= cnt;
        if (rise) begin
          o_lo_len   <= cnt;
          o_edge_cnt <= o_edge_cnt + 1'b1;
        end
        if (run_rise) begin
          o_period <= per;
          o_valid  <= 1'b1;
          if (per < o_min_period) o_min_period <= per;
          if (per > o_max_period) o_max_period <= per;
        end
        if ((run_rise && per_bad) || stuck) o_err <= 1'b1;
        unique case (1'b1)
          (state == S_IDLE): if (rise) state <= S_HI1;
          (state == S_HI1):  if (fall) state <= S_RUN;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rnd_clk_mon.sv
// tb_rnd_clk_mon: scoreboard bench for rnd_clk_mon.
// Expected periods are queued as edges are driven and popped on o_valid.
module tb_rnd_clk_mon;

  localparam int CW   = 8;
  localparam int ECW  = 16;
  localparam int MINP = 3;
  localparam int MAXP = 64;
`ifdef RND_CLK_MON_SYNC_EN
  localparam int SLAT = 2;
`else
  localparam int SLAT = 0;
`endif

  logic           clk = 1'b0;
  logic           rstn;
  logic           rnd;
  logic           clr;
  logic [CW-1:0]  hi_len;
  logic [CW-1:0]  lo_len;
  logic [CW:0]    period;
  logic           valid;
  logic [CW:0]    min_p;
  logic [CW:0]    max_p;
  logic [ECW-1:0] edge_cnt;
  logic           err;

  always #5 clk = ~clk;

  rnd_clk_mon #(
    .CW(CW), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP), .ECW(ECW)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_rnd_clk(rnd), .i_clr(clr),
    .o_hi_len(hi_len), .o_lo_len(lo_len), .o_period(period),
    .o_valid(valid), .o_min_period(min_p), .o_max_period(max_p),
    .o_edge_cnt(edge_cnt), .o_err(err)
  );

  typedef struct packed {
    logic [CW:0] per;
    logic [CW:0] mn;
    logic [CW:0] mx;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_valid = 0;
  int          n_push = 0;
  int          run_len = 0;
  int          last_hi = 0;
  int          mstate = 0;
  int          exp_edges = 0;
  logic        lvl = 1'b0;
  logic [CW:0] e_min = '1;
  logic [CW:0] e_max = '0;

  // one clock; outputs sampled on the falling edge, valids scored here
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (valid === 1'b1) begin
      n_valid++;
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid period=%0d", period);
      end else begin
        e = q.pop_front();
        if (period !== e.per) begin
          n_bad++;
          $display("FAIL sb_period got=%0d exp=%0d", period, e.per);
        end
        n_cmp++;
        if (min_p !== e.mn) begin
          n_bad++;
          $display("FAIL sb_min got=%0d exp=%0d", min_p, e.mn);
        end
        n_cmp++;
        if (max_p !== e.mx) begin
          n_bad++;
          $display("FAIL sb_max got=%0d exp=%0d", max_p, e.mx);
        end
      end
    end
  endtask

  task automatic model_edge(input logic v, input bit c);
    logic [CW:0] p;
    if (v) begin
      if (c) begin
        mstate    = 0;
        exp_edges = 0;
        e_min     = '1;
        e_max     = '0;
      end else begin
        exp_edges++;
        if (mstate == 2) begin
          p = (CW+1)'(last_hi + run_len);
          if (p < e_min) e_min = p;
          if (p > e_max) e_max = p;
          q.push_back('{per: p, mn: e_min, mx: e_max});
          n_push++;
        end else if (mstate == 0) begin
          mstate = 1;
        end
      end
    end else begin
      last_hi = run_len;
      if (mstate == 1) mstate = 2;
    end
    run_len = 1;
  endtask

  task automatic drive(input logic v, input int n, input bit clr_rise = 1'b0);
    for (int i = 0; i < n; i++) begin
      rnd = v;
      clr = clr_rise && (i == SLAT);
      if (i == 0 && v !== lvl) model_edge(v, clr_rise);
      else if (run_len < 255) run_len++;
      lvl = v;
      cyc();
    end
    clr = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    rnd  = 1'b0;
    clr  = 1'b0;
    repeat (4) cyc();
    rstn      = 1'b1;
    run_len   = 0;
    last_hi   = 0;
    mstate    = 0;
    exp_edges = 0;
    lvl       = 1'b0;
    e_min     = '1;
    e_max     = '0;
    n_valid   = 0;
    n_push    = 0;
    q.delete();
  endtask

  task automatic check_drained(input string tag);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_pending got=%0d exp=0", tag, q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (hi_len !== '0) begin
      n_bad++; $display("FAIL reset_hi got=%0d exp=0", hi_len);
    end
    n_cmp++;
    if (lo_len !== '0) begin
      n_bad++; $display("FAIL reset_lo got=%0d exp=0", lo_len);
    end
    n_cmp++;
    if (period !== '0) begin
      n_bad++; $display("FAIL reset_period got=%0d exp=0", period);
    end
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid got=%b exp=0", valid);
    end
    n_cmp++;
    if (min_p !== 9'h1FF) begin
      n_bad++; $display("FAIL reset_min got=%h exp=1ff", min_p);
    end
    n_cmp++;
    if (max_p !== '0) begin
      n_bad++; $display("FAIL reset_max got=%0d exp=0", max_p);
    end
    n_cmp++;
    if (edge_cnt !== '0) begin
      n_bad++; $display("FAIL reset_edges got=%0d exp=0", edge_cnt);
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL reset_err got=%b exp=0", err);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    drive(1'b0, 5);
    repeat (4) begin
      drive(1'b1, 3);
      drive(1'b0, 5);
    end
    drive(1'b0, 4);
    n_cmp++;
    if (hi_len !== 8'd3) begin
      n_bad++; $display("FAIL fixed_hi got=%0d exp=3", hi_len);
    end
    n_cmp++;
    if (lo_len !== 8'd5) begin
      n_bad++; $display("FAIL fixed_lo got=%0d exp=5", lo_len);
    end
    n_cmp++;
    if (period !== 9'd8) begin
      n_bad++; $display("FAIL fixed_period got=%0d exp=8", period);
    end
    n_cmp++;
    if (n_valid != 3) begin
      n_bad++; $display("FAIL fixed_valids got=%0d exp=3", n_valid);
    end
    n_cmp++;
    if (min_p !== 9'd8 || max_p !== 9'd8) begin
      n_bad++; $display("FAIL fixed_minmax got=%0d/%0d exp=8/8", min_p, max_p);
    end
    n_cmp++;
    if (edge_cnt !== 16'd4) begin
      n_bad++; $display("FAIL fixed_edges got=%0d exp=4", edge_cnt);
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL fixed_err got=%b exp=0", err);
    end
    check_drained("fixed");
  endtask

  task automatic test_random();
    logic [15:0] lfsr;
    int          h;
    int          l;
    int          tot;
    do_reset();
    drive(1'b0, 3);
    lfsr = 16'h0001;
    tot  = 0;
    while (tot < 1500) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      h    = 2 + int'(lfsr % 16'd30);
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      l    = 2 + int'(lfsr % 16'd30);
      drive(1'b1, h);
      drive(1'b0, l);
      tot += h + l;
    end
    drive(1'b0, 4);
    check_drained("rand");
    n_cmp++;
    if (n_valid != n_push || n_push < 10) begin
      n_bad++; $display("FAIL rand_valids got=%0d exp=%0d", n_valid, n_push);
    end
    n_cmp++;
    if (min_p !== e_min || max_p !== e_max) begin
      n_bad++;
      $display("FAIL rand_minmax got=%0d/%0d exp=%0d/%0d", min_p, max_p, e_min, e_max);
    end
    n_cmp++;
    if (edge_cnt !== ECW'(exp_edges)) begin
      n_bad++; $display("FAIL rand_edges got=%0d exp=%0d", edge_cnt, exp_edges);
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL rand_err got=%b exp=0", err);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    drive(1'b0, 2);
    drive(1'b1, 1);
    drive(1'b0, 1);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL glitch_pre_err got=%b exp=0", err);
    end
    drive(1'b1, 1);
    drive(1'b0, 1);
    drive(1'b1, 1);
    drive(1'b0, 4);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++; $display("FAIL glitch_err got=%b exp=1", err);
    end
    repeat (2) begin
      drive(1'b1, 3);
      drive(1'b0, 5);
    end
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++; $display("FAIL glitch_sticky got=%b exp=1", err);
    end
    check_drained("glitch");
  endtask

  task automatic test_stuck();
    do_reset();
    drive(1'b0, 5);
    drive(1'b1, 3);
    drive(1'b0, 5);
    drive(1'b1, 3);
    drive(1'b0, 5);
    drive(1'b1, 200);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL stuck_early_err got=%b exp=0", err);
    end
    drive(1'b1, 100);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++; $display("FAIL stuck_err got=%b exp=1", err);
    end
    drive(1'b0, 4);
    n_cmp++;
    if (hi_len !== 8'd255) begin
      n_bad++; $display("FAIL stuck_hi got=%0d exp=255", hi_len);
    end
    check_drained("stuck");
  endtask

  task automatic test_clr();
    do_reset();
    drive(1'b0, 5);
    drive(1'b1, 3);
    drive(1'b0, 5);
    drive(1'b1, 1);
    drive(1'b0, 1);
    drive(1'b1, 3);
    drive(1'b0, 5);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++; $display("FAIL clr_pre_err got=%b exp=1", err);
    end
    drive(1'b1, 4, 1'b1);
    n_cmp++;
    if (edge_cnt !== '0) begin
      n_bad++; $display("FAIL clr_edges got=%0d exp=0", edge_cnt);
    end
    n_cmp++;
    if (min_p !== 9'h1FF || max_p !== '0) begin
      n_bad++; $display("FAIL clr_minmax got=%h/%h exp=1ff/0", min_p, max_p);
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL clr_err got=%b exp=0", err);
    end
    n_cmp++;
    if (period !== 9'd2) begin
      n_bad++; $display("FAIL clr_period_kept got=%0d exp=2", period);
    end
    drive(1'b0, 5);
    drive(1'b1, 3);
    drive(1'b0, 5);
    drive(1'b1, 3);
    drive(1'b0, 4);
    n_cmp++;
    if (edge_cnt !== 16'd2) begin
      n_bad++; $display("FAIL clr_edges_after got=%0d exp=2", edge_cnt);
    end
    n_cmp++;
    if (min_p !== 9'd8 || max_p !== 9'd8) begin
      n_bad++; $display("FAIL clr_minmax_after got=%0d/%0d exp=8/8", min_p, max_p);
    end
    check_drained("clr");
  endtask

  initial begin
    rstn = 1'b0;
    rnd  = 1'b0;
    clr  = 1'b0;
    test_reset();
    test_fixed();
    test_random();
    test_glitch();
    test_stuck();
    test_clr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
